// File: rtl/calc_pkg.sv
// calc_pkg: address-width helpers derived from framebuffer geometry
package calc_pkg;
    function automatic int num_row_address_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction
    function automatic int num_column_address_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction
    function automatic int num_column_bytes(input int width);
        return (num_column_address_bits(width) + 7) / 8;
    endfunction
endpackage

// File: rtl/control_cmd_readpixel_tx_pkg.sv
// control_cmd_readpixel_tx_pkg: state encoding and checksum seed for the readback responder
package control_cmd_readpixel_tx_pkg;
    typedef enum logic [2:0] {
        S_ROW,
        S_COL,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_CSUM,
        S_DONE
    } readpixel_tx_state_t;
    localparam logic [7:0] CSUM_SEED = 8'hA5;
endpackage

// File: rtl/params_pkg.sv
// params_pkg: framebuffer geometry shared by the control_cmd_* handlers
package params_pkg;
    localparam int BYTES_PER_PIXEL = 2;
    localparam int PIXEL_HEIGHT = 240;
    localparam int PIXEL_WIDTH = 320;
endpackage

// File: rtl/control_cmd_readpixel_tx_latency_counter.sv
// readpixel_tx_latency_counter: down-counter flagging the cycle RAM read data is valid
module readpixel_tx_latency_counter #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);
    localparam int LW = $clog2(LATENCY + 1);
    logic [LW-1:0] cnt;
    // reload on each read strobe, then count down to empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= LW'(LATENCY);
        else if (cnt != '0) cnt <= cnt - LW'(1);
    end
    assign expire = cnt == LW'(1);
endmodule

// File: rtl/control_cmd_readpixel_tx.sv
// control_cmd_readpixel_tx: reads one pixel from framebuffer RAM and streams its bytes MSB-first
// optional trailing checksum byte: define CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
module control_cmd_readpixel_tx
    import calc_pkg::*;
    import control_cmd_readpixel_tx_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
    parameter int PIXEL_HEIGHT = params_pkg::PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH = params_pkg::PIXEL_WIDTH,
    parameter int RAM_READ_LATENCY = 1,
    parameter int _UNUSED = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic [7:0] data_in,
    output logic [num_row_address_bits(PIXEL_HEIGHT)-1:0] row,
    output logic [num_column_address_bits(PIXEL_WIDTH)-1:0] column,
    output logic [num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
    output logic ram_read_enable,
    output logic ram_access_start,
    input  logic [7:0] ram_data_in,
    output logic [7:0] tx_data,
    output logic tx_valid,
    input  logic tx_ready,
    output logic busy,
    output logic done
);
    localparam int RW = num_row_address_bits(PIXEL_HEIGHT);
    localparam int CW = num_column_address_bits(PIXEL_WIDTH);
    localparam int PW = num_pixelcolorselect_bits(BYTES_PER_PIXEL);
    localparam int COL_BYTES = num_column_bytes(PIXEL_WIDTH);
    localparam int CB = COL_BYTES * 8;
    localparam int CCW = $clog2(COL_BYTES + 1);
    localparam logic [8:0] ROW_LIM = 9'(PIXEL_HEIGHT);
    localparam logic [CB:0] COL_LIM = (CB + 1)'(PIXEL_WIDTH);
    localparam logic [PW-1:0] PIX_LAST = PW'(BYTES_PER_PIXEL - 1 + 0 * _UNUSED);
`ifdef CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
    localparam readpixel_tx_state_t S_LAST = S_CSUM;
    logic [7:0] csum_q;
`else
    localparam readpixel_tx_state_t S_LAST = S_DONE;
`endif

    readpixel_tx_state_t state, state_d;
    logic [7:0] row_q, tx_data_q;
    logic [CB-1:0] col_q, col_shift;
    logic [CCW-1:0] col_cnt;
    logic [PW-1:0] pixel_q;
    logic oor, col_last, hs, load, expire;

    // full command bytes are kept so oversized coordinates still fail the range check
    assign col_shift = CB'({col_q, data_in});
    assign col_last = col_cnt == CCW'(COL_BYTES - 1);
    assign oor = ({1'b0, row_q} >= ROW_LIM) || ({1'b0, col_q} >= COL_LIM);
    assign hs = tx_valid && tx_ready;
    assign row = row_q[RW-1:0];
    assign column = col_q[CW-1:0];
    assign pixel = pixel_q;
    assign tx_data = tx_data_q;

    readpixel_tx_latency_counter #(.LATENCY(RAM_READ_LATENCY)) u_lat (
        .clk(clk),
        .reset(reset),
        .load(load),
        .expire(expire)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_ROW;
        else state <= state_d;
    end

    // next state and control outputs; out-of-range coordinates bypass the RAM entirely
    always_comb begin
        state_d = state;
        load = 1'b0;
        ram_access_start = 1'b0;
        ram_read_enable = 1'b0;
        tx_valid = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state)
            S_ROW: begin
                busy = 1'b0;
                state_d = enable ? S_COL : S_ROW;
            end
            S_COL: state_d = (enable && col_last) ? S_ISSUE : S_COL;
            S_ISSUE: begin
                ram_read_enable = !oor;
                ram_access_start = !oor;
                load = !oor;
                state_d = oor ? S_SEND : S_WAIT;
            end
            S_WAIT: begin
                ram_read_enable = 1'b1;
                state_d = expire ? S_SEND : S_WAIT;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = (pixel_q != '0) ? (oor ? S_SEND : S_ISSUE) : S_LAST;
            end
            S_CSUM: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                state_d = S_ROW;
            end
            default: state_d = S_ROW;
        endcase
    end

    // coordinate capture, byte select countdown and transmit data holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
            col_cnt <= '0;
            pixel_q <= '0;
            tx_data_q <= '0;
`ifdef CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            if (state == S_ROW && enable) begin
                row_q <= data_in;
                col_cnt <= '0;
`ifdef CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
                csum_q <= CSUM_SEED;
`endif
            end
            if (state == S_COL && enable) begin
                col_q <= col_shift;
                col_cnt <= col_cnt + CCW'(1);
                pixel_q <= PIX_LAST;
            end
            if (state == S_ISSUE && oor) tx_data_q <= '0;
            if (state == S_WAIT && expire) tx_data_q <= ram_data_in;
            if (state == S_SEND && hs) begin
                if (pixel_q != '0) pixel_q <= pixel_q - PW'(1);
`ifdef CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
                csum_q <= csum_q ^ tx_data_q;
                if (pixel_q == '0) tx_data_q <= csum_q ^ tx_data_q;
`endif
            end
        end
    end
endmodule

// File: tb/tb_control_cmd_readpixel_tx.sv
// tb_control_cmd_readpixel_tx: scoreboard bench driving latency-1 and latency-3 instances in lockstep
module tb_control_cmd_readpixel_tx;
    import calc_pkg::*;
    localparam int BPP = params_pkg::BYTES_PER_PIXEL;
    localparam int H = params_pkg::PIXEL_HEIGHT;
    localparam int W = params_pkg::PIXEL_WIDTH;
    localparam int RW = num_row_address_bits(H);
    localparam int CW = num_column_address_bits(W);
    localparam int PW = num_pixelcolorselect_bits(BPP);
    localparam int COL_BYTES = num_column_bytes(W);
`ifdef CONTROL_CMD_READPIXEL_TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic v;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic [PW-1:0] p;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic tx_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_val(input int r, input int c, input int p);
        if (r == 3 && c == 5) return (p == 1) ? 8'h12 : 8'h34;
        return 8'(r * 7 + c * 3 + p * 85 + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [RW-1:0] row;
        logic [CW-1:0] column;
        logic [PW-1:0] pixel;
        logic ram_read_enable, ram_access_start, tx_valid, busy, done;
        logic [7:0] ram_data_in, tx_data;
        logic [RW+CW+PW+12:0] outs;
        logic [8:0] exp_q[$];
        req_t pipe[LAT] = '{default: '0};
        int strobes = 0;
        int re_cycles = 0;
        logic pv = 1'b0, ph = 1'b0, exp_done = 1'b0;
        logic [7:0] pd = 8'h00;
        logic [8:0] e;

        control_cmd_readpixel_tx #(.RAM_READ_LATENCY(LAT)) dut (
            .clk(clk),
            .reset(reset),
            .enable(enable),
            .data_in(data_in),
            .row(row),
            .column(column),
            .pixel(pixel),
            .ram_read_enable(ram_read_enable),
            .ram_access_start(ram_access_start),
            .ram_data_in(ram_data_in),
            .tx_data(tx_data),
            .tx_valid(tx_valid),
            .tx_ready(tx_ready),
            .busy(busy),
            .done(done)
        );

        assign outs = {row, column, pixel, ram_read_enable, ram_access_start, tx_data, tx_valid, busy, done};

        // RAM model: data is valid only in the cycle exactly LAT cycles after the strobe
        always @(posedge clk) begin
            pipe[0] <= '{ram_access_start, row, column, pixel};
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_data_in = pipe[LAT-1].v ?
            ram_val(int'(pipe[LAT-1].r), int'(pipe[LAT-1].c), int'(pipe[LAT-1].p)) : 8'hEE;

        initial forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                ph = 1'b0;
                exp_done = 1'b0;
            end else begin
                if (ram_access_start) strobes++;
                if (ram_read_enable) re_cycles++;
                if (pv && !ph) begin
                    chk($sformatf("hold_valid_lat%0d", LAT), tx_valid, 1);
                    chk($sformatf("hold_data_lat%0d", LAT), tx_data, pd);
                end
                if (done || exp_done) chk($sformatf("done_lat%0d", LAT), done, exp_done);
                exp_done = 1'b0;
                ph = tx_valid && tx_ready;
                if (ph) begin
                    if (exp_q.size() == 0) chk($sformatf("extra_byte_lat%0d", LAT), exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk($sformatf("tx_data_lat%0d", LAT), tx_data, e[7:0]);
                        exp_done = e[8];
                    end
                end
                pv = tx_valid;
                pd = tx_data;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int r, input int c);
        logic [8*COL_BYTES-1:0] cv;
        logic [7:0] v, cs;
        bit ok;
        ok = r < H && c < W;
        cs = 8'hA5;
        for (int p = BPP - 1; p >= 0; p--) begin
            v = ok ? ram_val(r, c, p) : 8'h00;
            cs ^= v;
            u[0].exp_q.push_back({!CSUM && p == 0, v});
            u[1].exp_q.push_back({!CSUM && p == 0, v});
        end
        if (CSUM) begin
            u[0].exp_q.push_back({1'b1, cs});
            u[1].exp_q.push_back({1'b1, cs});
        end
        cv = (8 * COL_BYTES)'(c);
        enable = 1'b1;
        data_in = 8'(r);
        cyc();
        for (int i = COL_BYTES - 1; i >= 0; i--) begin
            data_in = cv[8*i +: 8];
            cyc();
        end
        enable = 1'b0;
    endtask

    task automatic wait_idle(input bit bp);
        int k = 0;
        while ((u[0].exp_q.size() != 0 || u[1].exp_q.size() != 0 || u[0].busy || u[1].busy) && k < 400) begin
            tx_ready = bp ? (k % 8 == 7) : 1'b1;
            cyc();
            k++;
        end
        chk("idle_timeout", k < 400, 1);
        tx_ready = 1'b0;
        cyc(2);
    endtask

    task automatic run_cmd(input int r, input int c, input bit bp);
        int s0 = u[0].strobes;
        int s1 = u[1].strobes;
        int e0 = u[0].re_cycles;
        int e1 = u[1].re_cycles;
        bit ok = r < H && c < W;
        send_cmd(r, c);
        wait_idle(bp);
        chk("strobes_lat1", u[0].strobes - s0, ok ? BPP : 0);
        chk("strobes_lat3", u[1].strobes - s1, ok ? BPP : 0);
        chk("read_enable_cycles_lat1", u[0].re_cycles - e0, ok ? BPP * 2 : 0);
        chk("read_enable_cycles_lat3", u[1].re_cycles - e1, ok ? BPP * 4 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        cyc(3);
        chk("reset_outs_lat1", u[0].outs, 0);
        chk("reset_outs_lat3", u[1].outs, 0);
        reset = 1'b1;
        cyc(2);
        run_cmd(3, 5, 1'b0);
        run_cmd(3, 5, 1'b1);
        run_cmd(H, 5, 1'b0);
        run_cmd(3, W, 1'b1);
        run_cmd(H - 1, W - 1, 1'b0);
        run_cmd(0, 0, 1'b0);
        send_cmd(7, 100);
        enable = 1'b1;
        data_in = 8'h55;
        cyc(3);
        enable = 1'b0;
        k = 0;
        while (!(u[0].tx_valid && u[1].tx_valid) && k < 50) begin
            cyc();
            k++;
        end
        chk("valid_timeout", k < 50, 1);
        enable = 1'b1;
        data_in = 8'h01;
        cyc(2);
        enable = 1'b0;
        wait_idle(1'b0);
        run_cmd(10, 300, 1'b0);
        send_cmd(3, 5);
        cyc();
        reset = 1'b0;
        #1;
        chk("midreset_outs_lat1", u[0].outs, 0);
        chk("midreset_outs_lat3", u[1].outs, 0);
        u[0].exp_q.delete();
        u[1].exp_q.delete();
        cyc(2);
        chk("held_reset_outs_lat3", u[1].outs, 0);
        reset = 1'b1;
        cyc(2);
        run_cmd(3, 5, 1'b0);
        run_cmd(H - 1, W - 1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
